sqm_wr_scheduler: RTL and testbench

//  Shares the SQMUSIC register-write port between two requesters, port 0
//  (CPU latch path) and port 1 (sequencer/replay engine).

---
 rtl/sqm_wr_scheduler.sv | 149 ++++++++++++++
 tb/tb_sqm_wr_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sqm_wr_scheduler.sv
// Round-robin scheduler sharing the SQMUSIC register-write port between two
// requesters (port 0 CPU latch, port 1 sequencer), each with a small FIFO.

module sqm_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         sound_clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [AW:0]               wp, rp;
  logic [DEPTH-1:0][W-1:0]   mem;

  always_ff @(posedge sound_clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge sound_clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign dout  = mem[rp[AW-1:0]];
endmodule

module sqm_wr_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic       sound_clk,
  input  logic       reset_n,
  input  logic       p0_valid,
  output logic       p0_ready,
  input  logic [3:0] p0_adr,
  input  logic [7:0] p0_data,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [3:0] p1_adr,
  input  logic [7:0] p1_data,
  output logic [3:0] core_adr,
  output logic [7:0] core_data,
  output logic       core_wr,
  output logic       core_src,
  output logic       busy
);
  localparam int NUM_PORTS = 2;
  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef struct packed {
    logic [3:0] adr;
    logic [7:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAPW} state_t;

  wr_req_t [NUM_PORTS-1:0] req, head;
  logic    [NUM_PORTS-1:0] vld, push, pop, full, empty;

  state_t     state, nstate;
  logic [3:0] cnt;
  logic       last_grant, grant, take;

  assign vld    = {p1_valid, p0_valid};
  assign req[0] = {p0_adr, p0_data};
  assign req[1] = {p1_adr, p1_data};
  // Ready depends only on pointers; a same-cycle pop never opens a full port.
  assign push   = vld & ~full;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sqm_wr_fifo #(.DEPTH(DEPTH), .W($bits(wr_req_t))) u_fifo (
      .sound_clk (sound_clk),
      .reset_n   (reset_n),
      .push      (push[g]),
      .pop       (pop[g]),
      .din       (req[g]),
      .dout      (head[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  assign p0_ready = ~full[0];
  assign p1_ready = ~full[1];
  assign busy     = (state != IDLE) | ~&empty;

  always_ff @(posedge sound_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (take) nstate = ISSUE;
      ISSUE:   nstate = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (cnt == 4'd0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Grant: the only non-empty port, or the one not served last on a tie.
  always_comb begin
    take  = 1'b0;
    grant = 1'b0;
    pop   = '0;
    if (state == IDLE && !(&empty)) begin
      take  = 1'b1;
      grant = (!empty[0] && !empty[1]) ? ~last_grant : empty[0];
      pop[grant] = 1'b1;
    end
  end

  always_ff @(posedge sound_clk or negedge reset_n) begin
    if (!reset_n) begin
      core_adr   <= '0;
      core_data  <= '0;
      core_wr    <= 1'b0;
      core_src   <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      core_wr <= take;
      if (take) begin
        core_adr   <= head[grant].adr;
        core_data  <= head[grant].data;
        core_src   <= grant;
        last_grant <= grant;
      end
      if (state == ISSUE)                 cnt <= GAP_LD;
      else if (state == GAPW && cnt != 0) cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_sqm_wr_scheduler.sv
// Directed bench for sqm_wr_scheduler: GAP=1 instance plus a GAP=0 instance.

module tb_sqm_wr_scheduler;
  logic sound_clk = 1'b0;
  logic reset_n   = 1'b0;
  always #5 sound_clk = ~sound_clk;

  logic       p0_valid, p0_ready, p1_valid, p1_ready;
  logic [3:0] p0_adr, p1_adr, core_adr;
  logic [7:0] p0_data, p1_data, core_data;
  logic       core_wr, core_src, busy;

  logic       q0_valid, q0_ready, q1_valid, q1_ready;
  logic [3:0] q0_adr, q1_adr, z_adr;
  logic [7:0] q0_data, q1_data, z_data;
  logic       z_wr, z_src, z_busy;

  sqm_wr_scheduler #(.DEPTH(4), .GAP(1)) dut (
    .sound_clk(sound_clk), .reset_n(reset_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_adr(p0_adr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_adr(p1_adr), .p1_data(p1_data),
    .core_adr(core_adr), .core_data(core_data), .core_wr(core_wr),
    .core_src(core_src), .busy(busy)
  );

  sqm_wr_scheduler #(.DEPTH(4), .GAP(0)) dut0 (
    .sound_clk(sound_clk), .reset_n(reset_n),
    .p0_valid(q0_valid), .p0_ready(q0_ready), .p0_adr(q0_adr), .p0_data(q0_data),
    .p1_valid(q1_valid), .p1_ready(q1_ready), .p1_adr(q1_adr), .p1_data(q1_data),
    .core_adr(z_adr), .core_data(z_data), .core_wr(z_wr),
    .core_src(z_src), .busy(z_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k, t0;
  logic acc;
  logic [12:0] mq[$];
  int          mc[$];
  logic [11:0] zq[$];

  always @(posedge sound_clk) cyc <= cyc + 1;

  always @(posedge sound_clk) begin
    #1;
    if (core_wr) begin
      mq.push_back({core_src, core_adr, core_data});
      mc.push_back(cyc);
    end
    if (z_wr) zq.push_back({z_adr, z_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sound_clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_valid = 0; p0_adr = 0; p0_data = 0;
    p1_valid = 0; p1_adr = 0; p1_data = 0;
    q0_valid = 0; q0_adr = 0; q0_data = 0;
    q1_valid = 0; q1_adr = 0; q1_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    mq.delete(); mc.delete(); zq.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || z_busy) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    #12;
    // Reset state
    chk("rst_core", {core_wr, core_src, core_adr, core_data}, 0);
    chk("rst_ready", {p0_ready, p1_ready, q0_ready, q1_ready}, 4'hF);
    chk("rst_busy", {busy, z_busy}, 0);
    chk("rst_core0", {z_wr, z_src, z_adr, z_data}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single p0 write, latency and strobe width
    p0_valid = 1; p0_adr = 4'h7; p0_data = 8'h38;
    tick();
    p0_valid = 0;
    chk("t1_wr_n", core_wr, 0);
    chk("t1_busy_n", busy, 1);
    tick();
    chk("t1_wr_n1", core_wr, 1);
    chk("t1_word", {core_src, core_adr, core_data}, {1'b0, 4'h7, 8'h38});
    tick();
    chk("t1_wr_n2", core_wr, 0);
    chk("t1_busy_n2", busy, 1);
    tick();
    chk("t1_busy_n3", busy, 0);
    chk("t1_hold", {core_adr, core_data}, {4'h7, 8'h38});

    // 2: saturate p1 with valid held; full, no push-on-full, nothing lost
    do_reset();
    k = 0;
    p1_valid = 1; p1_adr = 0; p1_data = 8'h10;
    for (int i = 0; i < 60 && k < 8; i++) begin
      acc = p1_ready;
      tick();
      if (acc) k++;
      if (i == 5) chk("t2_full_i5", p1_ready, 0);
      if (i == 6) chk("t2_full_i6", p1_ready, 0);
      if (i == 7) chk("t2_free_i7", p1_ready, 1);
      if (k < 8) begin
        p1_adr = 4'(k); p1_data = 8'h10 + 8'(k);
      end else p1_valid = 0;
    end
    p1_valid = 0;
    wait_idle("t2_drain");
    chk("t2_count", mq.size(), 8);
    for (int j = 0; j < 8; j++)
      chk("t2_order", (j < mq.size()) ? mq[j] : 13'h1FFF, {1'b1, 4'(j), 8'h10 + 8'(j)});

    // 3: both ports preloaded, strict alternation with GAP+2 spacing
    do_reset();
    p0_valid = 1; p1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      p0_adr = 4'(8 + i);  p0_data = 8'h40 + 8'(i);
      p1_adr = 4'(12 + i); p1_data = 8'h80 + 8'(i);
      tick();
      if (i == 0) t0 = cyc;
    end
    p0_valid = 0; p1_valid = 0;
    wait_idle("t3_drain");
    chk("t3_count", mq.size(), 6);
    for (int j = 0; j < 6; j++)
      chk("t3_order", (j < mq.size()) ? mq[j] : 13'h1FFF,
          (j % 2 == 1) ? {1'b1, 4'(12 + j / 2), 8'h80 + 8'(j / 2)}
                       : {1'b0, 4'(8 + j / 2), 8'h40 + 8'(j / 2)});
    if (mc.size() == 6) begin
      chk("t3_first_lat", mc[0] - t0, 1);
      for (int j = 1; j < 6; j++) chk("t3_spacing", mc[j] - mc[j-1], 3);
    end else chk("t3_spacing_cnt", mc.size(), 6);

    // 4: GAP=0 instance, 4 writes on p0 -> 1,0,1,0,1,0,1
    do_reset();
    for (int i = 0; i < 9; i++) begin
      q0_valid = (i < 4); q0_adr = 4'(5 + i); q0_data = 8'hA0 + 8'(i);
      tick();
      if (i >= 1) chk("t4_wr_pattern", z_wr, 32'(i % 2));
    end
    q0_valid = 0;
    chk("t4_count", zq.size(), 4);
    for (int j = 0; j < 4; j++)
      chk("t4_order", (j < zq.size()) ? zq[j] : 12'hFFF, {4'(5 + j), 8'hA0 + 8'(j)});

    // 5: reset asserted mid-strobe discards queued writes
    do_reset();
    p0_valid = 1; p0_adr = 4'h1; p0_data = 8'h11;
    p1_valid = 1; p1_adr = 4'h2; p1_data = 8'h22;
    tick();
    p0_valid = 0; p1_adr = 4'h3; p1_data = 8'h33;
    tick();
    p1_valid = 0;
    chk("t5_pre_wr", core_wr, 1);
    chk("t5_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_wr", core_wr, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", {p0_ready, p1_ready}, 2'b11);
    mq.delete(); mc.delete();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("t5_no_replay", mq.size(), 0);
    chk("t5_idle", busy, 0);
    p0_valid = 1; p0_adr = 4'h9; p0_data = 8'h99;
    tick();
    p0_valid = 0;
    tick();
    chk("t5_new_wr", core_wr, 1);
    chk("t5_new_word", {core_src, core_adr, core_data}, {1'b0, 4'h9, 8'h99});

    // 6: continuous p0 pushes while draining, scoreboard against push log
    do_reset();
    k = 0;
    p0_valid = 1; p0_adr = 0; p0_data = 8'hC0;
    for (int i = 0; i < 100 && k < 12; i++) begin
      acc = p0_ready;
      tick();
      if (acc) k++;
      if (k < 12) begin
        p0_adr = 4'(k); p0_data = 8'hC0 + 8'(k);
      end else p0_valid = 0;
    end
    p0_valid = 0;
    wait_idle("t6_drain");
    chk("t6_count", mq.size(), 12);
    for (int j = 0; j < 12; j++)
      chk("t6_order", (j < mq.size()) ? mq[j] : 13'h1FFF, {1'b0, 4'(j), 8'hC0 + 8'(j)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
